// File: rtl/demux2_stream.sv
// demux2_stream: routes one valid/ready input stream to one of two output
// streams. in_sel steers each beat. Each output has its own 2-entry FIFO, so
// a stalled consumer on one side never blocks beats bound for the other.
//
// Ports:
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in_valid/in_ready    input handshake; in_sel picks destination (0/1)
//   in_data              input payload
//   out0_valid/ready     out0 handshake; out0_data is the buffer head
//   out1_valid/ready     out1 handshake; out1_data is the buffer head
//   cnt0, cnt1           wrap-around count of beats accepted into each output
module demux2_stream #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_sel,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out0_valid,
  input  logic               out0_ready,
  output logic [WIDTH-1:0]   out0_data,
  output logic               out1_valid,
  input  logic               out1_ready,
  output logic [WIDTH-1:0]   out1_data,
  output logic [COUNT_W-1:0] cnt0,
  output logic [COUNT_W-1:0] cnt1
);

  // Per-output storage: slot e0 is always the head, e1 the second entry.
  logic [WIDTH-1:0]   e0  [2];
  logic [WIDTH-1:0]   e1  [2];
  logic [1:0]         occ [2];
  logic [COUNT_W-1:0] cnt [2];

  logic [1:0] ready;
  logic [1:0] push;
  logic [1:0] pop;

  assign ready = {out1_ready, out0_ready};

  always_comb begin
    pop = '0;
    for (int unsigned k = 0; k < 2; k++) begin
      pop[k] = (occ[k] != 2'd0) && ready[k];
    end
  end

  // A full buffer still accepts when its head leaves in the same cycle.
  assign in_ready = in_sel ? ((occ[1] != 2'd2) || pop[1])
                           : ((occ[0] != 2'd2) || pop[0]);

  assign push = {in_valid && in_ready && in_sel,
                 in_valid && in_ready && !in_sel};

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < 2; k++) begin
        occ[k] <= '0;
        e0[k]  <= '0;
        e1[k]  <= '0;
        cnt[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < 2; k++) begin
        if (push[k]) cnt[k] <= cnt[k] + 1'b1;
        case ({push[k], pop[k]})
          2'b10: begin
            if (occ[k] == 2'd0) e0[k] <= in_data;
            else                e1[k] <= in_data;
            occ[k] <= occ[k] + 2'd1;
          end
          2'b01: begin
            // Popping the last entry leaves the head register untouched so
            // out_data holds its last value while empty.
            if (occ[k] == 2'd2) e0[k] <= e1[k];
            occ[k] <= occ[k] - 2'd1;
          end
          2'b11: begin
            if (occ[k] == 2'd2) begin
              e0[k] <= e1[k];
              e1[k] <= in_data;
            end else begin
              e0[k] <= in_data;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign out0_valid = (occ[0] != 2'd0);
  assign out1_valid = (occ[1] != 2'd0);
  assign out0_data  = e0[0];
  assign out1_data  = e0[1];
  assign cnt0       = cnt[0];
  assign cnt1       = cnt[1];

endmodule

// File: tb/tb_demux2_stream.sv
// Directed-vector bench for demux2_stream (WIDTH=32, COUNT_W=4).
module tb_demux2_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic        in_sel;
  logic [31:0] in_data;
  logic        out0_valid;
  logic        out0_ready;
  logic [31:0] out0_data;
  logic        out1_valid;
  logic        out1_ready;
  logic [31:0] out1_data;
  logic [3:0]  cnt0;
  logic [3:0]  cnt1;

  int total = 0;
  int bad   = 0;

  demux2_stream #(.WIDTH(32), .COUNT_W(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .cnt0       (cnt0),
    .cnt1       (cnt1)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 time unit after the edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
    out0_ready = 1'b0; out1_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_v0", out0_valid, 0);
    check("rst_v1", out1_valid, 0);
    check("rst_d0", out0_data, 0);
    check("rst_c0", cnt0, 0);
    check("rst_c1", cnt1, 0);

    // Routing to each port, one-cycle latency
    out0_ready = 1'b1; out1_ready = 1'b1;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hA5A5A5A5;
    #1 check("rt_rdy0", in_ready, 1);
    tick();
    in_sel = 1'b1; in_data = 32'h5A5A5A5A;
    #1;
    check("rt_v0", out0_valid, 1);
    check("rt_d0", out0_data, 32'hA5A5A5A5);
    check("rt_v1a", out1_valid, 0);
    check("rt_c0", cnt0, 1);
    check("rt_rdy1", in_ready, 1);
    tick();
    in_valid = 1'b0;
    #1;
    check("rt_v0b", out0_valid, 0);
    check("rt_v1", out1_valid, 1);
    check("rt_d1", out1_data, 32'h5A5A5A5A);
    check("rt_c1", cnt1, 1);
    tick();
    check("rt_v1c", out1_valid, 0);

    // Backpressure on out0
    out0_ready = 1'b0; out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'd1;
    #1 check("bp_rdy1", in_ready, 1);
    tick();
    in_data = 32'd2;
    #1 check("bp_rdy2", in_ready, 1);
    tick();
    in_data = 32'd3;
    #1 check("bp_rdy3", in_ready, 0);
    check("bp_head", out0_data, 32'd1);
    tick();
    check("bp_hold", out0_data, 32'd1);
    check("bp_cnt", cnt0, 3);
    out0_ready = 1'b1;
    #1 check("bp_rdy_pop", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_o2", out0_data, 32'd2);
    tick();
    check("bp_o3", out0_data, 32'd3);
    check("bp_v3", out0_valid, 1);
    tick();
    check("bp_empty", out0_valid, 0);
    check("bp_cnt4", cnt0, 4);
    check("bp_keep", out0_data, 32'd3);

    // Independence: out0 full and stalled, out1 still accepts
    out0_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b0; in_data = 32'h10;
    tick();
    in_data = 32'h11;
    tick();
    in_sel = 1'b1; in_data = 32'hBEEF;
    #1 check("ind_rdy", in_ready, 1);
    tick();
    in_sel = 1'b0;
    #1 check("ind_full0", in_ready, 0);
    in_valid = 1'b0;
    check("ind_v1", out1_valid, 1);
    check("ind_d1", out1_data, 32'hBEEF);
    check("ind_d0", out0_data, 32'h10);
    check("ind_c1", cnt1, 2);
    out1_ready = 1'b1;
    tick();
    check("ind_v1b", out1_valid, 0);

    // Reset mid-traffic with occ0=2; reset wins over push/pop
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0; in_data = 32'hDEAD;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0; in_valid = 1'b0;
    check("mr_v0", out0_valid, 0);
    check("mr_v1", out1_valid, 0);
    check("mr_c0", cnt0, 0);
    check("mr_c1", cnt1, 0);
    check("mr_d0", out0_data, 0);

    // Full buffer push+pop on out1
    out1_ready = 1'b0;
    in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h71;
    tick();
    in_data = 32'h72;
    tick();
    out1_ready = 1'b1; in_data = 32'h77;
    #1 check("fp_rdy", in_ready, 1);
    tick();
    out1_ready = 1'b0; in_data = 32'h99;
    #1 check("fp_full", in_ready, 0);
    in_valid = 1'b0;
    check("fp_h72", out1_data, 32'h72);
    check("fp_c1", cnt1, 3);
    out1_ready = 1'b1;
    tick();
    check("fp_h77", out1_data, 32'h77);
    check("fp_v77", out1_valid, 1);
    tick();
    check("fp_empty", out1_valid, 0);

    // Counter wrap: 17 beats into out0 with COUNT_W=4
    out0_ready = 1'b1; in_valid = 1'b1; in_sel = 1'b0;
    for (int i = 0; i < 17; i++) begin
      in_data = 32'h100 + i;
      tick();
      check($sformatf("wr_d%0d", i), out0_data, 32'h100 + i);
      check($sformatf("wr_v%0d", i), out0_valid, 1);
    end
    in_valid = 1'b0;
    check("wr_cnt", cnt0, 1);
    tick();
    check("wr_empty", out0_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
